// File: rtl/alu_pkg.sv
// Shared opcode constants and sequencer state encoding for the 8-bit ALU controller.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic accepts_input(state_e s);
    return (s == S_CMD) || (s == S_A) || (s == S_B);
  endfunction

endpackage

// File: rtl/alu_8bit.sv
// Combinational ALU: add (with carry out), sub, and, or. Carry is 0 for all but add.
module alu_8bit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    result = '0;
    cout   = 1'b0;
    unique case (sel)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        cout   = sum[WIDTH];
      end
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      default: result = a | b;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Collects command, operand A and operand B bytes, runs one ALU cycle, and presents the
// captured result/carry/zero on a valid/ready output until the consumer takes it.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             in_xfer;

  // Ready depends on state only so upstream never sees a combinational loop.
  assign in_xfer = in_valid && accepts_input(state_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_CMD: if (in_xfer) begin
        sel_d   = in_data[1:0];
        state_d = S_A;
      end
      S_A: if (in_xfer) begin
        a_d     = in_data;
        state_d = S_B;
      end
      S_B: if (in_xfer) begin
        b_d     = in_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_result;
        cout_d  = alu_cout;
        zero_d  = (alu_result == '0);
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_CMD;
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CMD;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready   = accepts_input(state_q);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_CMD);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;
  assign out_result = res_q;
  assign out_cout   = cout_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer wired to alu_8bit: per-cycle model comparison plus literals.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [1:0] alu_sel;
  logic       alu_cout;
  logic [7:0] out_result;
  logic       out_cout, out_zero, out_valid, out_ready, busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_cout   (alu_cout),
    .out_result (out_result),
    .out_cout   (out_cout),
    .out_zero   (out_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  alu_8bit #(.WIDTH(8)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .sel    (alu_sel),
    .result (alu_result),
    .cout   (alu_cout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from plain integer arithmetic; returns {zero, cout, result}.
  function automatic logic [9:0] ref_alu(input logic [1:0] s, input int a, input int b);
    int t;
    logic c;
    c = 1'b0;
    case (s)
      2'd0: begin t = a + b; c = (t > 255); t = t % 256; end
      2'd1: t = (a - b + 256) % 256;
      2'd2: t = a & b;
      default: t = a | b;
    endcase
    return {(t == 0), c, t[7:0]};
  endfunction

  // Model: bytes collected so far (3 means the compute cycle), and a result-pending flag.
  int         m_cnt  = 0;
  bit         m_done = 1'b0;
  logic [1:0] m_sel;
  logic [7:0] m_a, m_b, m_res;
  logic       m_cout, m_zero;
  logic [9:0] m_tmp;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_done = 1'b0;
      m_sel = '0; m_a = '0; m_b = '0; m_res = '0; m_cout = 1'b0; m_zero = 1'b0;
    end else if (m_done) begin
      if (out_ready) begin m_done = 1'b0; m_cnt = 0; end
    end else if (m_cnt == 3) begin
      m_tmp  = ref_alu(m_sel, int'(m_a), int'(m_b));
      m_res  = m_tmp[7:0];
      m_cout = m_tmp[8];
      m_zero = m_tmp[9];
      m_done = 1'b1;
    end else if (in_valid) begin
      case (m_cnt)
        0: m_sel = in_data[1:0];
        1: m_a   = in_data;
        default: m_b = in_data;
      endcase
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("ctl{in_ready,out_valid,busy}", {29'd0, in_ready, out_valid, busy},
            {29'd0, (m_cnt < 3) && !m_done, m_done, (m_cnt != 0) || m_done});
      check("alu_regs{sel,a,b}", {14'd0, alu_sel, alu_a, alu_b}, {14'd0, m_sel, m_a, m_b});
      check("out{zero,cout,result}", {22'd0, out_zero, out_cout, out_result},
            {22'd0, m_zero, m_cout, m_res});
    end
  end

  // Drivers change inputs 1 time unit after the rising edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic run_op(input string name, input logic [7:0] cmd, a, b,
                        input logic [7:0] er, input logic ec, ez);
    send_byte(cmd);
    send_byte(a);
    send_byte(b);
    check({name, "_valid_exec"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check({name, "_valid_done"}, {31'd0, out_valid}, 32'd1);
    check({name, "_result"}, {24'd0, out_result}, {24'd0, er});
    check({name, "_cout"}, {31'd0, out_cout}, {31'd0, ec});
    check({name, "_zero"}, {31'd0, out_zero}, {31'd0, ez});
    if (out_ready) begin
      @(posedge clk); #1;
      check({name, "_back_idle"}, {30'd0, in_ready, busy}, 32'd2);
    end
  endtask

  localparam logic [5:0] StallPat = 6'b101001;  // bit 0 first: 1-0-0-1-0-1

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    check("rst_ctl", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("rst_out", {22'd0, out_zero, out_cout, out_result}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_carry", 8'h00, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0);
    run_op("sub_wrap",  8'h01, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    run_op("and_zero",  8'hFE, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1);

    // Backpressure: output held while consumer stalls, junk input is refused.
    out_ready = 1'b0;
    run_op("bp_or", 8'h03, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'h99;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid_inready", {30'd0, out_valid, in_ready}, 32'd2);
      check("bp_hold_result", {24'd0, out_result}, 32'h5A);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", {30'd0, busy, in_ready}, 32'd1);
    check("bp_regs_kept", {14'd0, alu_sel, alu_a, alu_b}, {14'd0, 2'b11, 8'h0A, 8'h50});

    // Input stalls: bytes only on the valid cycles.
    k = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = StallPat[i];
      case (k)
        0: in_data = 8'h00;
        1: in_data = 8'h12;
        default: in_data = 8'h34;
      endcase
      if (!StallPat[i]) in_data = 8'hAA;
      else k++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stall_valid_exec", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("stall_result", {23'd0, out_valid, out_result}, {23'd0, 1'b1, 8'h46});
    check("stall_operands", {14'd0, alu_sel, alu_a, alu_b}, {14'd0, 2'b00, 8'h12, 8'h34});
    @(posedge clk); #1;

    // Reset after the A byte discards the partial command.
    send_byte(8'h01);
    send_byte(8'h77);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ctl", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("midrst_regs", {14'd0, alu_sel, alu_a, alu_b}, 32'd0);
    check("midrst_out", {22'd0, out_zero, out_cout, out_result}, 32'd0);
    run_op("post_rst_add", 8'h00, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
